// File: rtl/id_hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module : id_hazard_scoreboard_if
// Decode-side bundle between ID/HDU and the hazard scoreboard.
// Rev    : 1.0
// ============================================================================
interface id_hazard_scoreboard_if #(
    parameter int REGID_W = 5,
    parameter int DEPTH   = 4,
    parameter int LAT_W   = $clog2(DEPTH),
    parameter int SEL_W   = $clog2(DEPTH)
);
    logic               issue_valid;
    logic [REGID_W-1:0] rs1_regid;
    logic               rs1_read;
    logic [REGID_W-1:0] rs2_regid;
    logic               rs2_read;
    logic [REGID_W-1:0] rd_regid;
    logic               rd_write;
    logic [LAT_W-1:0]   rd_latency;
    logic               hold;
    logic               flush;
    logic               stall;
    logic               issue_fire;
    logic               ex_valid;
    logic [SEL_W-1:0]   ex_fwd_sel1;
    logic [SEL_W-1:0]   ex_fwd_sel2;
    logic [31:0]        stall_cycles;

    modport master (
        output issue_valid, rs1_regid, rs1_read, rs2_regid, rs2_read,
        output rd_regid, rd_write, rd_latency, hold, flush,
        input  stall, issue_fire, ex_valid, ex_fwd_sel1, ex_fwd_sel2, stall_cycles
    );

    modport slave (
        input  issue_valid, rs1_regid, rs1_read, rs2_regid, rs2_read,
        input  rd_regid, rd_write, rd_latency, hold, flush,
        output stall, issue_fire, ex_valid, ex_fwd_sel1, ex_fwd_sel2, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/id_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : id_hazard_scoreboard
// Stall and registered forward-select generation over DEPTH in-flight slots.
// Rev    : 1.0
// ============================================================================
module id_hazard_scoreboard #(
    parameter int REGID_W = 5,
    parameter int DEPTH   = 4,
    parameter int LAT_W   = $clog2(DEPTH),
    parameter int SEL_W   = $clog2(DEPTH)
) (
    input wire                    clk,
    input wire                    rst,
    id_hazard_scoreboard_if.slave sb
);
    localparam int               c_SLOT_LAST = DEPTH - 1;
    localparam logic [LAT_W-1:0] c_LAT_MIN   = LAT_W'(1);
    localparam logic [LAT_W-1:0] c_LAT_MAX   = LAT_W'(DEPTH - 1);

    logic               r_slot_valid [DEPTH];
    logic [REGID_W-1:0] r_slot_rd    [DEPTH];
    logic [LAT_W-1:0]   r_slot_lat   [DEPTH];

    logic               r_ex_valid;
    logic [SEL_W-1:0]   r_ex_sel1;
    logic [SEL_W-1:0]   r_ex_sel2;
    logic [31:0]        r_stall_cycles;

    logic [LAT_W-1:0]   w_lat_clamped;
    logic               w_hit1, w_hit2;
    logic [SEL_W-1:0]   w_idx1, w_idx2;
    logic [LAT_W-1:0]   w_lat1, w_lat2;
    logic               w_fwd1, w_fwd2;
    logic               w_stall1, w_stall2;
    logic [SEL_W-1:0]   w_sel1, w_sel2;
    logic               w_stall;
    logic               w_fire;

    always_comb begin
        w_lat_clamped = sb.rd_latency;
        if (sb.rd_latency == '0)
            w_lat_clamped = c_LAT_MIN;
        else if (32'(sb.rd_latency) >= 32'(DEPTH))
            w_lat_clamped = c_LAT_MAX;
    end

    // Scan oldest to youngest so the lowest matching slot is the last to assign.
    always_comb begin
        w_hit1 = 1'b0;
        w_idx1 = '0;
        w_lat1 = '0;
        w_hit2 = 1'b0;
        w_idx2 = '0;
        w_lat2 = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (r_slot_valid[k] && sb.rs1_read && (sb.rs1_regid != '0) &&
                (sb.rs1_regid == r_slot_rd[k])) begin
                w_hit1 = 1'b1;
                w_idx1 = SEL_W'(k);
                w_lat1 = r_slot_lat[k];
            end
            if (r_slot_valid[k] && sb.rs2_read && (sb.rs2_regid != '0) &&
                (sb.rs2_regid == r_slot_rd[k])) begin
                w_hit2 = 1'b1;
                w_idx2 = SEL_W'(k);
                w_lat2 = r_slot_lat[k];
            end
        end
    end

    // A hit in the last slot is served by the write-through regfile read.
    assign w_fwd1   = w_hit1 && (32'(w_idx1) != 32'(c_SLOT_LAST));
    assign w_fwd2   = w_hit2 && (32'(w_idx2) != 32'(c_SLOT_LAST));
    assign w_stall1 = w_fwd1 && ((32'(w_idx1) + 32'd1) < 32'(w_lat1));
    assign w_stall2 = w_fwd2 && ((32'(w_idx2) + 32'd1) < 32'(w_lat2));
    assign w_sel1   = w_fwd1 ? (w_idx1 + SEL_W'(1)) : '0;
    assign w_sel2   = w_fwd2 ? (w_idx2 + SEL_W'(1)) : '0;

    assign w_stall  = sb.issue_valid && !sb.flush && (w_stall1 || w_stall2);
    assign w_fire   = sb.issue_valid && !w_stall && !sb.hold && !sb.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_slot_valid[k] <= 1'b0;
                r_slot_rd[k]    <= '0;
                r_slot_lat[k]   <= '0;
            end
            r_ex_valid     <= 1'b0;
            r_ex_sel1      <= '0;
            r_ex_sel2      <= '0;
            r_stall_cycles <= '0;
        end else if (!sb.hold) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_slot_valid[k] <= r_slot_valid[k-1];
                r_slot_rd[k]    <= r_slot_rd[k-1];
                r_slot_lat[k]   <= r_slot_lat[k-1];
            end
            r_slot_valid[0] <= w_fire && sb.rd_write && (sb.rd_regid != '0);
            r_slot_rd[0]    <= sb.rd_regid;
            r_slot_lat[0]   <= w_lat_clamped;
            r_ex_valid      <= w_fire;
            r_ex_sel1       <= w_fire ? w_sel1 : '0;
            r_ex_sel2       <= w_fire ? w_sel2 : '0;
            if (w_stall && sb.issue_valid && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign sb.stall        = w_stall;
    assign sb.issue_fire   = w_fire;
    assign sb.ex_valid     = r_ex_valid;
    assign sb.ex_fwd_sel1  = r_ex_sel1;
    assign sb.ex_fwd_sel2  = r_ex_sel2;
    assign sb.stall_cycles = r_stall_cycles;
endmodule
`default_nettype wire

// File: tb/tb_id_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : tb_id_hazard_scoreboard
// Directed scenarios plus randomized traffic against an age-based producer model.
// Rev    : 1.0
// ============================================================================
module tb_id_hazard_scoreboard;
    localparam int REGID_W = 5;
    localparam int DEPTH   = 4;
    localparam int LAT_W   = 2;
    localparam int SEL_W   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_hazard_scoreboard_if #(.REGID_W(REGID_W), .DEPTH(DEPTH), .LAT_W(LAT_W), .SEL_W(SEL_W)) sb_if ();

    id_hazard_scoreboard #(.REGID_W(REGID_W), .DEPTH(DEPTH), .LAT_W(LAT_W), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: in-flight producers tagged with their age since entering slot 0.
    typedef struct {
        int rd;
        int lat;
        int age;
    } entry_t;
    entry_t m_q[$];
    bit     m_stall, m_fire;
    int     m_sel1, m_sel2;
    bit     m_ex_valid;
    int     m_ex_sel1, m_ex_sel2;
    longint m_cnt;

    function automatic void model_src(input bit en, input int rs, output bit stl, output int sel);
        int best = -1;
        int blat = 0;
        stl = 1'b0;
        sel = 0;
        if (en && rs != 0)
            foreach (m_q[i])
                if (m_q[i].rd == rs && (best < 0 || m_q[i].age < best)) begin
                    best = m_q[i].age;
                    blat = m_q[i].lat;
                end
        if (best >= 0 && best <= DEPTH - 2) begin
            if (best + 1 < blat) stl = 1'b1;
            else sel = best + 1;
        end
    endfunction

    function automatic void model_eval();
        bit s1, s2;
        model_src(sb_if.rs1_read, int'(sb_if.rs1_regid), s1, m_sel1);
        model_src(sb_if.rs2_read, int'(sb_if.rs2_regid), s2, m_sel2);
        m_stall = sb_if.issue_valid && !sb_if.flush && (s1 || s2);
        m_fire  = sb_if.issue_valid && !m_stall && !sb_if.hold && !sb_if.flush;
    endfunction

    task automatic tick();
        int lat;
        entry_t e;
        model_eval();
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_ex_valid = 1'b0;
            m_ex_sel1  = 0;
            m_ex_sel2  = 0;
            m_cnt      = 0;
        end else if (!sb_if.hold) begin
            if (m_stall && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            foreach (m_q[i]) m_q[i].age++;
            for (int i = m_q.size() - 1; i >= 0; i--)
                if (m_q[i].age > DEPTH - 1) m_q.delete(i);
            m_ex_valid = m_fire;
            m_ex_sel1  = m_fire ? m_sel1 : 0;
            m_ex_sel2  = m_fire ? m_sel2 : 0;
            if (m_fire && sb_if.rd_write && sb_if.rd_regid != 0) begin
                lat = int'(sb_if.rd_latency);
                if (lat == 0) lat = 1;
                if (lat >= DEPTH) lat = DEPTH - 1;
                e.rd  = int'(sb_if.rd_regid);
                e.lat = lat;
                e.age = 0;
                m_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input int rs1, input bit r1, input int rs2, input bit r2,
                         input int rd, input bit w, input int lat, input bit h, input bit f);
        sb_if.issue_valid = v;
        sb_if.rs1_regid   = REGID_W'(rs1);
        sb_if.rs1_read    = r1;
        sb_if.rs2_regid   = REGID_W'(rs2);
        sb_if.rs2_read    = r2;
        sb_if.rd_regid    = REGID_W'(rd);
        sb_if.rd_write    = w;
        sb_if.rd_latency  = LAT_W'(lat);
        sb_if.hold        = h;
        sb_if.flush       = f;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (sb_if.ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_ex_valid: got %b want 0", sb_if.ex_valid); end
        n_vec++; if (sb_if.ex_fwd_sel1 !== 2'd0) begin n_err++; $display("FAIL reset_sel1: got %0d want 0", sb_if.ex_fwd_sel1); end
        n_vec++; if (sb_if.ex_fwd_sel2 !== 2'd0) begin n_err++; $display("FAIL reset_sel2: got %0d want 0", sb_if.ex_fwd_sel2); end
        n_vec++; if (sb_if.stall_cycles !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", sb_if.stall_cycles); end
        drive(1, 3, 1, 4, 1, 0, 0, 1, 0, 0);
        n_vec++; if (sb_if.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", sb_if.stall); end
        n_vec++; if (sb_if.issue_fire !== 1'b1) begin n_err++; $display("FAIL reset_fire: got %b want 1", sb_if.issue_fire); end
    endtask

    task automatic test_alu_back_to_back();
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        n_vec++; if (sb_if.issue_fire !== 1'b1) begin n_err++; $display("FAIL alu_prod_fire: got %b want 1", sb_if.issue_fire); end
        tick();
        drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
        n_vec++; if (sb_if.stall !== 1'b0) begin n_err++; $display("FAIL alu_stall: got %b want 0", sb_if.stall); end
        tick();
        n_vec++; if (sb_if.ex_valid !== 1'b1) begin n_err++; $display("FAIL alu_ex_valid: got %b want 1", sb_if.ex_valid); end
        n_vec++; if (sb_if.ex_fwd_sel1 !== 2'd1) begin n_err++; $display("FAIL alu_sel1: got %0d want 1", sb_if.ex_fwd_sel1); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 0, 6, 1, 2, 0, 0);
        tick();
        drive(1, 0, 0, 6, 1, 0, 0, 1, 0, 0);
        n_vec++; if (sb_if.stall !== 1'b1) begin n_err++; $display("FAIL lu_stall1: got %b want 1", sb_if.stall); end
        n_vec++; if (sb_if.issue_fire !== 1'b0) begin n_err++; $display("FAIL lu_fire1: got %b want 0", sb_if.issue_fire); end
        tick();
        n_vec++; if (sb_if.ex_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got %b want 0", sb_if.ex_valid); end
        n_vec++; if (sb_if.stall !== 1'b0) begin n_err++; $display("FAIL lu_stall2: got %b want 0", sb_if.stall); end
        n_vec++; if (sb_if.stall_cycles !== 32'd1) begin n_err++; $display("FAIL lu_count: got %0d want 1", sb_if.stall_cycles); end
        tick();
        n_vec++; if (sb_if.ex_valid !== 1'b1) begin n_err++; $display("FAIL lu_ex_valid: got %b want 1", sb_if.ex_valid); end
        n_vec++; if (sb_if.ex_fwd_sel2 !== 2'd2) begin n_err++; $display("FAIL lu_sel2: got %0d want 2", sb_if.ex_fwd_sel2); end
        n_vec++; if (sb_if.stall_cycles !== 32'd1) begin n_err++; $display("FAIL lu_count_hold: got %0d want 1", sb_if.stall_cycles); end
    endtask

    task automatic test_youngest_wins();
        do_reset();
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 7, 1, 2, 0, 0);
        tick();
        drive(1, 7, 1, 0, 0, 0, 0, 1, 0, 0);
        n_vec++; if (sb_if.stall !== 1'b1) begin n_err++; $display("FAIL yw_stall1: got %b want 1", sb_if.stall); end
        tick();
        n_vec++; if (sb_if.stall !== 1'b0) begin n_err++; $display("FAIL yw_stall2: got %b want 0", sb_if.stall); end
        tick();
        n_vec++; if (sb_if.ex_fwd_sel1 !== 2'd2) begin n_err++; $display("FAIL yw_sel1: got %0d want 2", sb_if.ex_fwd_sel1); end
    endtask

    task automatic test_x0_nowrite();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        drive(1, 0, 1, 0, 1, 9, 0, 2, 0, 0);
        n_vec++; if (sb_if.stall !== 1'b0) begin n_err++; $display("FAIL x0_stall: got %b want 0", sb_if.stall); end
        tick();
        n_vec++; if (sb_if.ex_fwd_sel1 !== 2'd0) begin n_err++; $display("FAIL x0_sel1: got %0d want 0", sb_if.ex_fwd_sel1); end
        drive(1, 9, 1, 0, 1, 0, 0, 1, 0, 0);
        n_vec++; if (sb_if.stall !== 1'b0) begin n_err++; $display("FAIL nowr_stall: got %b want 0", sb_if.stall); end
        tick();
        n_vec++; if (sb_if.ex_fwd_sel1 !== 2'd0) begin n_err++; $display("FAIL nowr_sel1: got %0d want 0", sb_if.ex_fwd_sel1); end
        n_vec++; if (sb_if.ex_fwd_sel2 !== 2'd0) begin n_err++; $display("FAIL nowr_sel2: got %0d want 0", sb_if.ex_fwd_sel2); end
    endtask

    task automatic test_hold_flush();
        do_reset();
        drive(1, 0, 0, 0, 0, 6, 1, 2, 0, 0);
        tick();
        drive(1, 0, 0, 6, 1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (sb_if.stall !== 1'b1) begin n_err++; $display("FAIL hold_stall[%0d]: got %b want 1", i, sb_if.stall); end
            tick();
            n_vec++; if (sb_if.ex_valid !== 1'b1) begin n_err++; $display("FAIL hold_ex_valid[%0d]: got %b want 1", i, sb_if.ex_valid); end
            n_vec++; if (sb_if.stall_cycles !== 32'd0) begin n_err++; $display("FAIL hold_count[%0d]: got %0d want 0", i, sb_if.stall_cycles); end
        end
        drive(1, 0, 0, 6, 1, 0, 0, 1, 0, 0);
        n_vec++; if (sb_if.stall !== 1'b1) begin n_err++; $display("FAIL hold_release_stall: got %b want 1", sb_if.stall); end
        tick();
        n_vec++; if (sb_if.stall_cycles !== 32'd1) begin n_err++; $display("FAIL hold_release_count: got %0d want 1", sb_if.stall_cycles); end
        tick();
        n_vec++; if (sb_if.ex_fwd_sel2 !== 2'd2) begin n_err++; $display("FAIL hold_sel2: got %0d want 2", sb_if.ex_fwd_sel2); end
        drive(1, 0, 0, 0, 0, 6, 1, 2, 0, 0);
        tick();
        drive(1, 0, 0, 6, 1, 0, 0, 1, 0, 1);
        n_vec++; if (sb_if.stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", sb_if.stall); end
        n_vec++; if (sb_if.issue_fire !== 1'b0) begin n_err++; $display("FAIL flush_fire: got %b want 0", sb_if.issue_fire); end
        tick();
        n_vec++; if (sb_if.ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_ex_valid: got %b want 0", sb_if.ex_valid); end
        n_vec++; if (sb_if.stall_cycles !== 32'd1) begin n_err++; $display("FAIL flush_count: got %0d want 1", sb_if.stall_cycles); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        drive(1, 0, 0, 0, 0, 10, 1, 2, 0, 0);
        tick();
        drive(1, 10, 1, 0, 0, 11, 1, 1, 0, 0);
        tick();
        tick();
        drive(1, 11, 1, 0, 0, 12, 1, 2, 0, 0);
        tick();
        n_vec++; if (sb_if.ex_fwd_sel1 !== 2'd1) begin n_err++; $display("FAIL mid_pre_sel1: got %0d want 1", sb_if.ex_fwd_sel1); end
        n_vec++; if (sb_if.stall_cycles !== 32'd1) begin n_err++; $display("FAIL mid_pre_count: got %0d want 1", sb_if.stall_cycles); end
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        rst = 1'b0;
        n_vec++; if (sb_if.ex_valid !== 1'b0) begin n_err++; $display("FAIL mid_ex_valid: got %b want 0", sb_if.ex_valid); end
        n_vec++; if (sb_if.ex_fwd_sel1 !== 2'd0) begin n_err++; $display("FAIL mid_sel1: got %0d want 0", sb_if.ex_fwd_sel1); end
        n_vec++; if (sb_if.stall_cycles !== 32'd0) begin n_err++; $display("FAIL mid_count: got %0d want 0", sb_if.stall_cycles); end
        drive(1, 12, 1, 11, 1, 0, 0, 1, 0, 0);
        n_vec++; if (sb_if.stall !== 1'b0) begin n_err++; $display("FAIL mid_stall: got %b want 0", sb_if.stall); end
        tick();
        n_vec++; if (sb_if.ex_fwd_sel1 !== 2'd0) begin n_err++; $display("FAIL mid_after_sel1: got %0d want 0", sb_if.ex_fwd_sel1); end
        n_vec++; if (sb_if.ex_fwd_sel2 !== 2'd0) begin n_err++; $display("FAIL mid_after_sel2: got %0d want 0", sb_if.ex_fwd_sel2); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 9) < 8,
                  int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 4)), $urandom_range(0, 9) < 8,
                  int'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
            model_eval();
            n_vec++; if (sb_if.stall !== m_stall) begin n_err++; $display("FAIL rnd_stall @%0d: got %b want %b", n, sb_if.stall, m_stall); end
            n_vec++; if (sb_if.issue_fire !== m_fire) begin n_err++; $display("FAIL rnd_fire @%0d: got %b want %b", n, sb_if.issue_fire, m_fire); end
            tick();
            n_vec++; if (sb_if.ex_valid !== m_ex_valid) begin n_err++; $display("FAIL rnd_ex_valid @%0d: got %b want %b", n, sb_if.ex_valid, m_ex_valid); end
            n_vec++; if (sb_if.ex_fwd_sel1 !== SEL_W'(m_ex_sel1)) begin n_err++; $display("FAIL rnd_sel1 @%0d: got %0d want %0d", n, sb_if.ex_fwd_sel1, m_ex_sel1); end
            n_vec++; if (sb_if.ex_fwd_sel2 !== SEL_W'(m_ex_sel2)) begin n_err++; $display("FAIL rnd_sel2 @%0d: got %0d want %0d", n, sb_if.ex_fwd_sel2, m_ex_sel2); end
            n_vec++; if (sb_if.stall_cycles !== 32'(m_cnt)) begin n_err++; $display("FAIL rnd_count @%0d: got %0d want %0d", n, sb_if.stall_cycles, m_cnt); end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_cnt = 0;
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_youngest_wins();
        test_x0_nowrite();
        test_hold_flush();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/id_hazard_scoreboard.md
# id_hazard_scoreboard

Parametrised hazard and forwarding tracker for the decode stage. It generalises the fixed two-stage EX/MEM forward check and single-cycle load-use stall to a pipeline of `DEPTH` in-flight slots with per-instruction result latency. It sits beside the decode logic:
- It consumes decoded register IDs and read/write enables.
- It issues a combinational stall to the HDU.
- It produces registered forward selects that travel with the instruction into EX.

## Interface
Parameters:
- `REGID_W`, default 5: register ID width; register 0 is hardwired zero.
- `DEPTH`, default 4: tracked slots after ID (slot 0 = ID/EX register, slot `DEPTH-1` = WB/regfile write); must be ≥ 2.
- `LAT_W`, default `$clog2(DEPTH)`: width of `rd_latency`.
- `SEL_W`, default `$clog2(DEPTH)`: width of the forward selects.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `issue_valid`, in, 1: valid decoded instruction present in ID.
- `rs1_regid`, in, `REGID_W`: source 1 ID.
- `rs1_read`, in, 1: source 1 used.
- `rs2_regid`, in, `REGID_W`: source 2 ID.
- `rs2_read`, in, 1: source 2 used.
- `rd_regid`, in, `REGID_W`: destination ID.
- `rd_write`, in, 1: destination written.
- `rd_latency`, in, `LAT_W`: first slot whose pipeline register holds the result (ALU=1, load=2).
- `hold`, in, 1: global pipeline freeze (e.g. memory wait).
- `flush`, in, 1: squash the ID instruction (branch/trap).
- `stall`, out, 1: combinational; ID must not advance.
- `issue_fire`, out, 1: combinational; `issue_valid & ~stall & ~hold & ~flush`.
- `ex_valid`, out, 1: registered; slot 0 holds an issued instruction.
- `ex_fwd_sel1`, out, `SEL_W`: registered; operand 1 source for the instruction in EX (0 = regfile value captured in ID, j = pipeline register of slot j).
- `ex_fwd_sel2`, out, `SEL_W`: registered; same as `ex_fwd_sel1` for operand 2.
- `stall_cycles`, out, 32: registered saturating count of cycles with `stall & issue_valid & ~hold`.

## Operation
Slot state:
- Each slot k (0..`DEPTH-1`) stores `valid`, `rd`, and `lat`.
- `rd_latency` is clamped: 0 becomes 1, and values ≥ `DEPTH` become `DEPTH-1`.

Match detection, per source s:
- Slot k matches when `slot[k].valid & rs_read & rs==slot[k].rd & rs!=0`.
- The lowest matching k (youngest producer) wins. Older matches are ignored even if they are ready.
- If no slot matches, the forward select is 0.

Stall rule:
- A winning match at k with k ≤ `DEPTH-2` forwards from slot k+1. It is legal only when k+1 ≥ `slot[k].lat`; otherwise the source stalls.
- A winning match at k = `DEPTH-1` selects 0. The regfile is write-through, so ID already reads the new value.
- `stall` = `issue_valid` & (source 1 stalls | source 2 stalls). `stall` is 0 when `issue_valid` = 0.

Slot and output update on a clock edge with `hold` = 0:
- Slot k+1 takes slot k.
- If `issue_fire` = 1:
  - slot 0 takes {`rd_write & rd_regid!=0`, `rd_regid`, clamped `rd_latency`};
  - `ex_valid` = 1;
  - `ex_fwd_selN` = computed select.
- Otherwise:
  - slot 0 becomes invalid (bubble);
  - `ex_valid` = 0;
  - `ex_fwd_selN` = 0.
- The oldest slot's entry drops out.

Other events:
- `hold` = 1: all slots, `ex_*` and `stall_cycles` keep their values. `stall` is still evaluated.
- `flush` has priority over `issue_valid`: it inserts a bubble and never stalls the flush itself.
- Reset: all slots invalid, `ex_valid` = 0, `ex_fwd_sel1/2` = 0, `stall_cycles` = 0. Reset mid-operation discards all in-flight entries and wins over `hold`.

## Timing
- `stall` and `issue_fire` are combinational from the ID inputs and slot state in the same cycle. They carry no dependency on `ex_*` outputs.
- An issued instruction appears in slot 0 and on `ex_*` one cycle after `issue_fire`.
- Slot j corresponds to j cycles after entry to slot 0, excluding hold cycles.
- A latency-L producer followed directly by a consumer stalls the consumer L-1 cycles. The consumer then reaches EX with `ex_fwd_sel` = L.
- `stall_cycles` updates one cycle after the counted cycle and saturates at `32'hFFFF_FFFF`.

## Test plan
All scenarios use `DEPTH` = 4.
- **ALU back-to-back:** issue `x5` (lat 1), then a reader of rs1=`x5`. Required: `stall`=0, and the next cycle shows `ex_fwd_sel1`=1, `ex_valid`=1.
- **Load-use:** issue `x6` with lat 2, then rs2=`x6`. Required: `stall`=1 for exactly one cycle, `stall_cycles`=1, then `ex_fwd_sel2`=2.
- **Youngest wins:** `x7` lat 1, then `x7` lat 2, then a reader of `x7`. Required: the reader stalls one cycle and then gets sel=2, even though the older producer is ready.
- **x0 and no-write:** producer with `rd`=0 or `rd_write`=0, then a reader of `x0`. Required: `stall`=0 and sel=0 in all cycles.
- **Hold and flush:** hold 3 cycles during a load-use stall. Required: slots, `ex_*` and `stall_cycles` are frozen. Then a flush with `issue_valid`=1 gives `issue_fire`=0 and `ex_valid`=0 on the next cycle.
- **Reset mid-stream:** assert `rst` while 3 slots are valid. Required: next cycle `ex_valid`=0, sels=0, counter=0, and a reader of the former producer's `rd` gets `stall`=0 and sel=0.
